// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: drives the PC mux select and update-enable through boot,
// imem backpressure, branch/trap redirects and the post-redirect flush window.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h4000_0000,
    parameter int unsigned BOOT_CYCLES  = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap_valid,
    input  logic [31:0] trap_target,
    input  logic        imem_req_ready,
    output logic        imem_req_valid,
    output logic [1:0]  pcsrc,
    output logic [31:0] alu_addr,
    output logic        pc_hold,
    output logic        flush,
    output logic        boot_done,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL, S_FLUSH} state_t;

    localparam logic [1:0]  PC_RESET   = 2'd0;
    localparam logic [1:0]  PC_ALU     = 2'd1;
    localparam logic [1:0]  PC_SEQ     = 2'd2;
    localparam logic [31:0] BOOT_LOAD  = 32'(BOOT_CYCLES - 1);
    localparam logic [31:0] FLUSH_LOAD = 32'(FLUSH_CYCLES - 1);

    if (BOOT_CYCLES < 1) begin : g_bad_boot
        $error("fetch_ctrl: BOOT_CYCLES must be >= 1");
    end
    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("fetch_ctrl: FLUSH_CYCLES must be >= 1");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_vector
        $error("fetch_ctrl: RESET_PC must be word aligned");
    end

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        pend_v, pend_v_nxt;
    logic        pend_trap, pend_trap_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;
    logic        boot_done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_BOOT;
            cnt       <= BOOT_LOAD;
            pend_v    <= 1'b0;
            pend_trap <= 1'b0;
            pend_tgt  <= '0;
            boot_done <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend_v    <= pend_v_nxt;
            pend_trap <= pend_trap_nxt;
            pend_tgt  <= pend_tgt_nxt;
            boot_done <= boot_done_nxt;
            if (state == S_STALL) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        pend_v_nxt     = pend_v;
        pend_trap_nxt  = pend_trap;
        pend_tgt_nxt   = pend_tgt;
        boot_done_nxt  = boot_done;
        pcsrc          = PC_SEQ;
        pc_hold        = 1'b0;
        flush          = 1'b1;
        imem_req_valid = 1'b0;
        alu_addr       = '0;

        case (state)
            S_BOOT: begin
                pcsrc = PC_RESET;
                if (cnt == 32'd0) begin
                    state_nxt     = S_RUN;
                    boot_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end

            S_RUN: begin
                flush          = 1'b0;
                imem_req_valid = 1'b1;
                if (trap_valid || br_taken) begin
                    pcsrc     = PC_ALU;
                    alu_addr  = trap_valid ? trap_target : br_target;
                    state_nxt = S_FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end else if (!imem_req_ready) begin
                    pc_hold   = 1'b1;
                    state_nxt = S_STALL;
                end
            end

            S_STALL: begin
                flush          = 1'b0;
                imem_req_valid = 1'b1;
                if (!imem_req_ready) begin
                    pc_hold = 1'b1;
                    // A pending trap is sticky; only a newer trap may replace it.
                    if (trap_valid) begin
                        pend_v_nxt    = 1'b1;
                        pend_trap_nxt = 1'b1;
                        pend_tgt_nxt  = trap_target;
                    end else if (br_taken && !(pend_v && pend_trap)) begin
                        pend_v_nxt    = 1'b1;
                        pend_trap_nxt = 1'b0;
                        pend_tgt_nxt  = br_target;
                    end
                end else if (trap_valid || br_taken || pend_v) begin
                    if (trap_valid)               alu_addr = trap_target;
                    else if (pend_v && pend_trap) alu_addr = pend_tgt;
                    else if (br_taken)            alu_addr = br_target;
                    else                          alu_addr = pend_tgt;
                    pcsrc      = PC_ALU;
                    state_nxt  = S_FLUSH;
                    cnt_nxt    = FLUSH_LOAD;
                    pend_v_nxt = 1'b0;
                end else begin
                    state_nxt = S_RUN;
                end
            end

            S_FLUSH: begin
                pc_hold = 1'b1;
                if (trap_valid) begin
                    pcsrc    = PC_ALU;
                    pc_hold  = 1'b0;
                    alu_addr = trap_target;
                    cnt_nxt  = FLUSH_LOAD;
                end else if (cnt == 32'd0) begin
                    state_nxt = S_RUN;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end

            default: begin
                state_nxt = S_BOOT;
                cnt_nxt   = BOOT_LOAD;
            end
        endcase
    end

endmodule
